// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
// Power-up and recovery sequencer for the clock-generation PLLs.
// Holds the PLLs in reset, waits for a synchronized lock, requires the lock
// to stay high for STABLE_CYCLES before releasing core reset, and retries or
// gives up on lock timeout.
// Build option: define PLL_SEQ_AUTORETRY_EN to allow up to MAX_RETRIES
// re-attempts after a lock timeout; without it the first timeout is fatal.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_areset,
  output logic       core_reset,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retries,
  output logic [2:0] state
);

  // One shared counter sized for the longest interval it ever has to reach.
  localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  // Terminal counts: the counter starts at 0 on state entry, so the last
  // cycle of an N-cycle interval is count N-1.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

`ifdef PLL_SEQ_AUTORETRY_EN
  localparam bit AUTORETRY = 1'b1;
`else
  localparam bit AUTORETRY = 1'b0;
`endif

  // With auto-retry off the limit is zero, so the first timeout goes to FAIL
  // and the retry counter can never move.
  localparam logic [3:0] RETRY_LIMIT = AUTORETRY ? 4'(MAX_RETRIES) : 4'd0;

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    RUN        = 3'd3,
    FAIL       = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       retries_reg, retries_next;
  logic             lock_meta_reg, locked_s_reg;
  logic             pll_areset_reg, pll_areset_next;
  logic             core_reset_reg, core_reset_next;
  logic             ready_reg, ready_next;
  logic             fail_reg, fail_next;

  // Two-flop synchronizer for the raw asynchronous lock; nothing else reads the pin.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      lock_meta_reg <= 1'b0;
      locked_s_reg  <= 1'b0;
    end else begin
      lock_meta_reg <= pll_locked;
      locked_s_reg  <= lock_meta_reg;
    end
  end

  // State, counter, retry count and registered outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg      <= RESET_HOLD;
      cnt_reg        <= '0;
      retries_reg    <= '0;
      pll_areset_reg <= 1'b1;
      core_reset_reg <= 1'b1;
      ready_reg      <= 1'b0;
      fail_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      retries_reg    <= retries_next;
      pll_areset_reg <= pll_areset_next;
      core_reset_reg <= core_reset_next;
      ready_reg      <= ready_next;
      fail_reg       <= fail_next;
    end
  end

  // Next-state logic; outputs are decoded from the state being entered so
  // they change on the same edge as the state itself.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + CNT_W'(1);
    retries_next = retries_reg;

    case (state_reg)
      RESET_HOLD: begin
        if (cnt_reg == RST_LAST) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end
      end
      WAIT_LOCK: begin
        // Lock is checked first so it wins over a coincident timeout.
        if (locked_s_reg) begin
          state_next = STABLE;
          cnt_next   = '0;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          cnt_next = '0;
          if (retries_reg != RETRY_LIMIT) begin
            retries_next = retries_reg + 4'd1;
            state_next   = RESET_HOLD;
          end else begin
            state_next = FAIL;
          end
        end
      end
      STABLE: begin
        // Any drop restarts the wait with a fresh timeout budget.
        if (!locked_s_reg) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == STABLE_LAST) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: begin
        cnt_next = cnt_reg;
        if (!locked_s_reg) begin
          state_next = RESET_HOLD;
          cnt_next   = '0;
        end
      end
      FAIL: begin
        cnt_next = cnt_reg;
      end
      default: begin
        state_next = RESET_HOLD;
        cnt_next   = '0;
      end
    endcase

    // A restart request overrides everything and begins a fresh sequence.
    if (restart) begin
      state_next   = RESET_HOLD;
      cnt_next     = '0;
      retries_next = '0;
    end

    pll_areset_next = (state_next == RESET_HOLD) || (state_next == FAIL);
    core_reset_next = (state_next != RUN);
    ready_next      = (state_next == RUN);
    fail_next       = (state_next == FAIL);
  end

  assign pll_areset = pll_areset_reg;
  assign core_reset = core_reset_reg;
  assign ready      = ready_reg;
  assign fail       = fail_reg;
  assign retries    = retries_reg;
  assign state      = state_reg;

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Power-up and recovery sequencer for the core's clock-generation PLLs. Drives the PLL reset, watches the combined raw lock flag, releases core reset only after lock has been stable for a programmed time, and retries or declares failure on lock timeout. Runs on the free-running 50 MHz board clock, ahead of every PLL-derived domain; `core_reset` feeds the per-domain reset synchronizers.

## Interface
Parameters:
- `RST_CYCLES`, 16: cycles `pll_areset` is held per attempt (≥1).
- `LOCK_TIMEOUT`, 65535: cycles allowed in WAIT_LOCK before a timeout (≥1).
- `STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before release (≥1).
- `MAX_RETRIES`, 3: timeouts tolerated before FAIL (0..15).

Ports:
- `clk_sys` in 1: free-running reference clock (board 50 MHz).
- `reset` in 1: synchronous, active-high; restarts the sequence.
- `pll_locked` in 1: raw asynchronous AND of all PLL lock outputs.
- `restart` in 1: single-cycle pulse, requests full re-sequence (e.g. video standard change).
- `pll_areset` out 1: reset to all PLLs.
- `core_reset` out 1: held high until clocks are valid.
- `ready` out 1: clocks locked and stable.
- `fail` out 1: sticky lock failure.
- `retries` out 4: timeouts counted in the current sequence.
- `state` out 3: debug state code.

## Operation
- `pll_locked` passes a 2-FF synchronizer → `locked_s`; logic never reads the raw pin.
- One shared counter `cnt`, width clog2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1); cleared on every state entry.
- States (code): RESET_HOLD(0), WAIT_LOCK(1), STABLE(2), RUN(3), FAIL(4).
- RESET_HOLD: after RST_CYCLES cycles → WAIT_LOCK.
- WAIT_LOCK: `locked_s`=1 → STABLE; else at cnt reaching LOCK_TIMEOUT → timeout handling. Lock and expiry in same cycle: lock wins.
- STABLE: `locked_s`=0 → WAIT_LOCK (timeout budget restarts); STABLE_CYCLES consecutive high cycles → RUN.
- RUN: `locked_s`=0 → RESET_HOLD; `retries` unchanged.
- FAIL: absorbing; left only via `reset` or `restart`.
- `restart` in any state → RESET_HOLD, `retries` and `fail` cleared. `reset` and `restart` together: reset behaviour (identical result).
- Outputs registered, decoded from the state being entered: `pll_areset`=1 in RESET_HOLD and FAIL; `core_reset`=1 in all states except RUN; `ready`=1 only in RUN; `fail`=1 only in FAIL.

## Timing
- Reset values: state RESET_HOLD, `pll_areset`=1, `core_reset`=1, `ready`=0, `fail`=0, `retries`=0, `cnt`=0.
- `pll_areset` high exactly RST_CYCLES cycles per attempt.
- Raw lock rise → `locked_s` after 2 cycles; STABLE entered 1 cycle later; `ready` rises and `core_reset` falls STABLE_CYCLES cycles after STABLE entry (STABLE_CYCLES+3 after raw rise if lock stays high).
- Lock loss in RUN: `core_reset`=1, `ready`=0, `pll_areset`=1 on the 3rd edge after raw fall (2 sync + 1 transition).
- Timeout edge: `retries` increments on the transition edge.

## Configuration
- `PLL_SEQ_AUTORETRY_EN` defined: timeout with `retries` < MAX_RETRIES → `retries`+1, RESET_HOLD; timeout with `retries` = MAX_RETRIES → FAIL.
- Not defined: first timeout → FAIL; `retries` constant 0; MAX_RETRIES ignored.

## Test plan
(RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRIES=2)
- Reset, raw lock rises 10 cycles after `pll_areset` falls -> `pll_areset` high exactly 4 cycles; `ready`=1, `core_reset`=0 exactly 11 cycles after raw rise; `retries`=0.
- Lock glitches low 1 cycle at STABLE count 5, then stays high -> back to WAIT_LOCK, re-enters STABLE, `ready` only after 8 further consecutive high cycles.
- Lock never asserts, AUTORETRY_EN defined -> three 4-cycle `pll_areset` pulses, `retries` 0→1→2, FAIL after 3rd timeout, `fail`=1, `pll_areset` held 1.
- Same stimulus, macro undefined -> FAIL after first 100-cycle WAIT_LOCK, `retries`=0.
- In RUN, raw lock drops -> 3rd edge: `core_reset`=1, `ready`=0, `state`=0, `pll_areset`=1 for 4 cycles, then normal relock.
- In FAIL, pulse `restart`; separately, assert `restart` mid-STABLE -> next cycle state 0, `fail`=0, `retries`=0, `cnt` restarted.
